// File: rtl/module_scheduler_if.sv
// Handshake bundle between the game FSM / puzzle modules and the module scheduler.
// Every signal is a single-cycle pulse or a level. There is no backpressure.
interface module_scheduler_if #(
    parameter int NUM_MODULES = 4
);
    logic                   begin_setup;
    logic                   begin_timer;
    logic [NUM_MODULES-1:0] module_enable;
    logic [NUM_MODULES-1:0] mod_solved;
    logic [NUM_MODULES-1:0] mod_strike;
    logic                   timer_expired;
    logic                   game_won;
    logic                   game_lost;
    logic [1:0]             strikes;
    logic [NUM_MODULES-1:0] solved_mask;
    logic                   strike_pulse;
    logic [2:0]             sched_state;

    modport master (
        output begin_setup, begin_timer, module_enable, mod_solved, mod_strike, timer_expired,
        input  game_won, game_lost, strikes, solved_mask, strike_pulse, sched_state
    );

    modport slave (
        input  begin_setup, begin_timer, module_enable, mod_solved, mod_strike, timer_expired,
        output game_won, game_lost, strikes, solved_mask, strike_pulse, sched_state
    );
endinterface

// File: rtl/module_scheduler.sv
// Bomb round scheduler: it tracks solves and strikes across modules and decides WON or LOST. Every result is registered one edge after its inputs.
// There is no backpressure. Pulses that arrive outside ARMED, or that come from disabled or already-solved modules, are dropped.
module module_scheduler #(
    parameter int NUM_MODULES = 4,
    parameter int MAX_STRIKES = 3
) (
    input logic               clock,
    input logic               reset_n,
    module_scheduler_if.slave bus
);
    localparam int CW = $clog2(NUM_MODULES + 1) + 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_SETUP = 3'b001,
        S_ARMED = 3'b100,
        S_WON   = 3'b010,
        S_LOST  = 3'b011
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [NUM_MODULES-1:0] r_enable, w_enable_nxt;
    logic [NUM_MODULES-1:0] r_solved, w_solved_nxt;
    logic [1:0]             r_strikes, w_strikes_nxt;
    logic                   r_strike_pulse, w_strike_pulse_nxt;

    logic [NUM_MODULES-1:0] w_live, w_acc_solve, w_acc_strike, w_solved_after;
    logic [CW-1:0]          w_strike_cnt, w_strike_sum;
    logic                   w_lose, w_win;

    // Only modules that are enabled and still unsolved can contribute events.
    always_comb begin
        w_live         = r_enable & ~r_solved;
        w_acc_solve    = bus.mod_solved & w_live;
        w_acc_strike   = bus.mod_strike & w_live;
        w_strike_cnt   = '0;
        for (int i = 0; i < NUM_MODULES; i++) begin
            w_strike_cnt = w_strike_cnt + CW'(w_acc_strike[i]);
        end
        w_strike_sum   = CW'(r_strikes) + w_strike_cnt;
        w_solved_after = r_solved | w_acc_solve;
        w_lose         = bus.timer_expired || (w_strike_sum >= CW'(MAX_STRIKES));
        w_win          = ((w_solved_after & r_enable) == r_enable);
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_enable_nxt       = r_enable;
        w_solved_nxt       = r_solved;
        w_strikes_nxt      = r_strikes;
        w_strike_pulse_nxt = 1'b0;
        case (r_state)
            S_IDLE, S_WON, S_LOST: begin
                if (bus.begin_setup) begin
                    w_state_nxt   = S_SETUP;
                    w_enable_nxt  = bus.module_enable;
                    w_solved_nxt  = '0;
                    w_strikes_nxt = '0;
                end
            end
            S_SETUP: begin
                if (bus.begin_timer) begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                w_solved_nxt       = w_solved_after;
                w_strike_pulse_nxt = |w_acc_strike;
                w_strikes_nxt      = (w_strike_sum >= CW'(MAX_STRIKES)) ? 2'(MAX_STRIKES)
                                                                        : w_strike_sum[1:0];
                // A loss outranks a simultaneous win.
                if (w_lose) begin
                    w_state_nxt = S_LOST;
                end else if (w_win) begin
                    w_state_nxt = S_WON;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_enable       <= '0;
            r_solved       <= '0;
            r_strikes      <= '0;
            r_strike_pulse <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_enable       <= w_enable_nxt;
            r_solved       <= w_solved_nxt;
            r_strikes      <= w_strikes_nxt;
            r_strike_pulse <= w_strike_pulse_nxt;
        end
    end

    assign bus.game_won     = (r_state == S_WON);
    assign bus.game_lost    = (r_state == S_LOST);
    assign bus.strikes      = r_strikes;
    assign bus.solved_mask  = r_solved;
    assign bus.strike_pulse = r_strike_pulse;
    assign bus.sched_state  = r_state;
endmodule

// File: tb/tb_module_scheduler.sv
// Testbench for module_scheduler. Directed scenario tasks run first, then a random run that is checked against a round-level model.
module tb_module_scheduler;
    localparam int N = 4;
    localparam int MS = 3;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fails = 0;

    module_scheduler_if #(.NUM_MODULES(N)) bus ();

    module_scheduler #(.NUM_MODULES(N), .MAX_STRIKES(MS)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.begin_setup   = 1'b0;
        bus.begin_timer   = 1'b0;
        bus.module_enable = '0;
        bus.mod_solved    = '0;
        bus.mod_strike    = '0;
        bus.timer_expired = 1'b0;
    endtask

    // Starts a round and arms it. The DUT is in ARMED on return.
    task automatic arm(input logic [N-1:0] mask);
        bus.begin_setup = 1'b1;
        bus.module_enable = mask;
        cyc();
        bus.begin_setup = 1'b0;
        bus.module_enable = '0;
        bus.begin_timer = 1'b1;
        cyc();
        bus.begin_timer = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
        n_checks++;
        if ({bus.game_won, bus.game_lost, bus.strikes, bus.solved_mask, bus.strike_pulse, bus.sched_state} !== 12'h000) begin
            n_fails++;
            $display("FAIL reset_outputs: got won=%b lost=%b strikes=%0d mask=%b pulse=%b state=%b want all zero",
                     bus.game_won, bus.game_lost, bus.strikes, bus.solved_mask, bus.strike_pulse, bus.sched_state);
        end
    endtask

    task automatic test_solve_win();
        arm(4'b0101);
        n_checks++;
        if (bus.sched_state !== 3'b100) begin
            n_fails++;
            $display("FAIL win_armed_state: got %b want 100", bus.sched_state);
        end
        bus.mod_solved = 4'b0001; cyc(); bus.mod_solved = '0;
        n_checks++;
        if (bus.solved_mask !== 4'b0001 || bus.game_won !== 1'b0) begin
            n_fails++;
            $display("FAIL win_first_solve: got mask=%b won=%b want 0001 0", bus.solved_mask, bus.game_won);
        end
        bus.mod_solved = 4'b0100; cyc(); bus.mod_solved = '0;
        n_checks++;
        if (bus.solved_mask !== 4'b0101 || bus.game_won !== 1'b1 || bus.sched_state !== 3'b010) begin
            n_fails++;
            $display("FAIL win_second_solve: got mask=%b won=%b state=%b want 0101 1 010",
                     bus.solved_mask, bus.game_won, bus.sched_state);
        end
    endtask

    task automatic test_strikes_lost();
        arm(4'b1111);
        n_checks++;
        if (bus.solved_mask !== 4'b0000 || bus.strikes !== 2'd0) begin
            n_fails++;
            $display("FAIL lost_new_round_clear: got mask=%b strikes=%0d want 0000 0", bus.solved_mask, bus.strikes);
        end
        for (int m = 1; m <= 3; m++) begin
            bus.mod_strike = 4'(1 << m); cyc(); bus.mod_strike = '0;
            n_checks++;
            if (bus.strikes !== 2'(m) || bus.strike_pulse !== 1'b1 || bus.game_lost !== (m == 3)) begin
                n_fails++;
                $display("FAIL lost_strike_%0d: got strikes=%0d pulse=%b lost=%b want %0d 1 %b",
                         m, bus.strikes, bus.strike_pulse, bus.game_lost, m, (m == 3));
            end
        end
        cyc();
        n_checks++;
        if (bus.strike_pulse !== 1'b0 || bus.strikes !== 2'd3 || bus.game_lost !== 1'b1) begin
            n_fails++;
            $display("FAIL lost_hold: got pulse=%b strikes=%0d lost=%b want 0 3 1",
                     bus.strike_pulse, bus.strikes, bus.game_lost);
        end
    endtask

    task automatic test_multi_strike();
        arm(4'b1111);
        bus.mod_strike = 4'b0001; cyc(); bus.mod_strike = '0;
        cyc();
        n_checks++;
        if (bus.strikes !== 2'd1 || bus.strike_pulse !== 1'b0) begin
            n_fails++;
            $display("FAIL multi_pre: got strikes=%0d pulse=%b want 1 0", bus.strikes, bus.strike_pulse);
        end
        bus.mod_strike = 4'b0011; cyc(); bus.mod_strike = '0;
        n_checks++;
        if (bus.strikes !== 2'd3 || bus.strike_pulse !== 1'b1 || bus.game_lost !== 1'b1) begin
            n_fails++;
            $display("FAIL multi_strike: got strikes=%0d pulse=%b lost=%b want 3 1 1",
                     bus.strikes, bus.strike_pulse, bus.game_lost);
        end
        cyc();
        n_checks++;
        if (bus.strike_pulse !== 1'b0) begin
            n_fails++;
            $display("FAIL multi_single_pulse: got pulse=%b want 0", bus.strike_pulse);
        end
    endtask

    task automatic test_win_vs_timer();
        arm(4'b0011);
        bus.mod_solved = 4'b0001; cyc();
        bus.mod_solved = 4'b0010; bus.timer_expired = 1'b1; cyc();
        bus.mod_solved = '0; bus.timer_expired = 1'b0;
        n_checks++;
        if (bus.game_lost !== 1'b1 || bus.game_won !== 1'b0 || bus.sched_state !== 3'b011) begin
            n_fails++;
            $display("FAIL timer_priority: got lost=%b won=%b state=%b want 1 0 011",
                     bus.game_lost, bus.game_won, bus.sched_state);
        end
        bus.mod_solved = 4'b0011; cyc(); bus.mod_solved = '0;
        n_checks++;
        if (bus.game_won !== 1'b0 || bus.game_lost !== 1'b1) begin
            n_fails++;
            $display("FAIL timer_lost_hold: got won=%b lost=%b want 0 1", bus.game_won, bus.game_lost);
        end
    endtask

    task automatic test_ignored();
        arm(4'b0011);
        bus.mod_solved = 4'b0001; cyc(); bus.mod_solved = '0;
        bus.mod_solved = 4'b1000; bus.mod_strike = 4'b1000; cyc();
        n_checks++;
        if (bus.solved_mask !== 4'b0001 || bus.strikes !== 2'd0 || bus.strike_pulse !== 1'b0) begin
            n_fails++;
            $display("FAIL ignore_disabled: got mask=%b strikes=%0d pulse=%b want 0001 0 0",
                     bus.solved_mask, bus.strikes, bus.strike_pulse);
        end
        bus.mod_solved = 4'b0001; bus.mod_strike = 4'b0001; cyc();
        bus.mod_solved = '0; bus.mod_strike = '0;
        cyc();
        n_checks++;
        if (bus.solved_mask !== 4'b0001 || bus.strikes !== 2'd0 || bus.strike_pulse !== 1'b0) begin
            n_fails++;
            $display("FAIL ignore_solved: got mask=%b strikes=%0d pulse=%b want 0001 0 0",
                     bus.solved_mask, bus.strikes, bus.strike_pulse);
        end
        bus.begin_setup = 1'b1; bus.module_enable = 4'b1111; cyc();
        bus.begin_setup = 1'b0; bus.module_enable = '0;
        n_checks++;
        if (bus.sched_state !== 3'b100 || bus.solved_mask !== 4'b0001) begin
            n_fails++;
            $display("FAIL ignore_setup_armed: got state=%b mask=%b want 100 0001", bus.sched_state, bus.solved_mask);
        end
    endtask

    task automatic test_empty_mask();
        reset_n = 1'b0; cyc(); reset_n = 1'b1;
        arm(4'b0000);
        n_checks++;
        if (bus.sched_state !== 3'b100) begin
            n_fails++;
            $display("FAIL empty_armed: got state=%b want 100", bus.sched_state);
        end
        cyc();
        n_checks++;
        if (bus.sched_state !== 3'b010 || bus.game_won !== 1'b1) begin
            n_fails++;
            $display("FAIL empty_win: got state=%b won=%b want 010 1", bus.sched_state, bus.game_won);
        end
    endtask

    task automatic test_reset_mid_round();
        arm(4'b1111);
        bus.mod_strike = 4'b0011; cyc(); bus.mod_strike = '0;
        n_checks++;
        if (bus.strikes !== 2'd2) begin
            n_fails++;
            $display("FAIL midreset_pre: got strikes=%0d want 2", bus.strikes);
        end
        reset_n = 1'b0; cyc(); reset_n = 1'b1;
        n_checks++;
        if ({bus.game_won, bus.game_lost, bus.strikes, bus.solved_mask, bus.strike_pulse, bus.sched_state} !== 12'h000) begin
            n_fails++;
            $display("FAIL midreset_outputs: got strikes=%0d mask=%b pulse=%b state=%b want all zero",
                     bus.strikes, bus.solved_mask, bus.strike_pulse, bus.sched_state);
        end
        bus.begin_timer = 1'b1; cyc(); bus.begin_timer = 1'b0;
        n_checks++;
        if (bus.sched_state !== 3'b000) begin
            n_fails++;
            $display("FAIL idle_ignores_timer: got state=%b want 000", bus.sched_state);
        end
    endtask

    // Round-level reference model. Phase: 0 idle, 1 setup, 2 armed, 3 won, 4 lost.
    int             m_phase;
    logic [N-1:0]   m_en, m_solved;
    int             m_strikes;
    bit             m_pulse;
    logic [2:0]     phase_code [5] = '{3'b000, 3'b001, 3'b100, 3'b010, 3'b011};

    task automatic model_step();
        int n;
        logic [N-1:0] s_ok;
        if (!reset_n) begin
            m_phase = 0; m_en = '0; m_solved = '0; m_strikes = 0; m_pulse = 0;
            return;
        end
        m_pulse = 0;
        if (m_phase == 1) begin
            if (bus.begin_timer) m_phase = 2;
        end else if (m_phase == 2) begin
            n = 0;
            s_ok = '0;
            for (int i = 0; i < N; i++) begin
                if (m_en[i] && !m_solved[i]) begin
                    if (bus.mod_strike[i]) n++;
                    if (bus.mod_solved[i]) s_ok[i] = 1'b1;
                end
            end
            m_solved = m_solved | s_ok;
            m_pulse = (n > 0);
            if (bus.timer_expired || m_strikes + n >= MS) m_phase = 4;
            else if ((m_solved & m_en) == m_en) m_phase = 3;
            m_strikes = (m_strikes + n > MS) ? MS : m_strikes + n;
        end else if (bus.begin_setup) begin
            m_phase = 1; m_en = bus.module_enable; m_solved = '0; m_strikes = 0;
        end
    endtask

    task automatic test_random();
        logic [11:0] exp_v, got_v;
        m_phase = 0; m_en = '0; m_solved = '0; m_strikes = 0; m_pulse = 0;
        reset_n = 1'b0; cyc(); reset_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            reset_n           = ($urandom_range(0, 199) != 0);
            bus.begin_setup   = ($urandom_range(0, 14) == 0);
            bus.begin_timer   = ($urandom_range(0, 5) == 0);
            bus.module_enable = 4'($urandom);
            bus.mod_solved    = 4'($urandom & $urandom & $urandom);
            bus.mod_strike    = 4'($urandom & $urandom & $urandom & $urandom);
            bus.timer_expired = ($urandom_range(0, 59) == 0);
            model_step();
            cyc();
            exp_v = {m_phase == 3, m_phase == 4, 2'(m_strikes), m_solved, m_pulse, phase_code[m_phase]};
            got_v = {bus.game_won, bus.game_lost, bus.strikes, bus.solved_mask, bus.strike_pulse, bus.sched_state};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fails++;
                $display("FAIL random_cycle_%0d: got won,lost,strk,mask,pulse,state=%b want %b", c, got_v, exp_v);
            end
        end
        reset_n = 1'b1;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_solve_win();
        test_strikes_lost();
        test_multi_strike();
        test_win_vs_timer();
        test_ignored();
        test_empty_mask();
        test_reset_mid_round();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
